// File: rtl/hc_pkg.sv
// Shared types and widths for the clocked 74xx component models.
package hc_pkg;

    localparam int HC_ADDR_W   = 3;
    localparam int HC_SETTLE_W = 4;

    // Encoding matches the {le_n, mr_n} pin pair directly.
    typedef enum logic [1:0] {
        MODE_DEMUX  = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_MEMORY = 2'b11
    } mode_e;

    typedef struct packed {
        logic                 mr_n;
        logic                 le_n;
        logic                 d;
        logic [HC_ADDR_W-1:0] a;
    } pins_t;

endpackage

// File: rtl/hc259_if.sv
// Pin bundle of the 74HC259 addressable latch; master drives the inputs, slave drives Q.
interface hc259_if;

    logic p1, p2, p3;
    logic p13, p14, p15;
    logic p4, p5, p6, p7;
    logic p9, p10, p11, p12;

    modport master (
        output p1, p2, p3, p13, p14, p15,
        input  p4, p5, p6, p7, p9, p10, p11, p12
    );

    modport slave (
        input  p1, p2, p3, p13, p14, p15,
        output p4, p5, p6, p7, p9, p10, p11, p12
    );

endinterface

// File: rtl/hc_sync.sv
// Pin input stage: 2-flop synchronizer when HC259_SYNC_EN is defined, else a single capture register.
module hc_sync #(
    parameter int               W         = 1,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

`ifdef HC259_SYNC_EN
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RESET_VAL;
        else     q <= d;
    end
`endif

endmodule

// File: rtl/hc259.sv
// 74HC259 8-bit addressable latch with address-settle qualification.
// Input stage depth is selected by HC259_SYNC_EN (see hc_sync).
module hc259
    import hc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic    clk,
    input  logic    rst,
    hc259_if.slave  pins
);

    localparam logic [HC_SETTLE_W-1:0] SETTLE_MAX = HC_SETTLE_W'(SETTLE_CYCLES);
    // Reset sample decodes as MEMORY at address 0.
    localparam pins_t PIN_RST = '{mr_n: 1'b1, le_n: 1'b1, d: 1'b0, a: '0};

    pins_t                  raw;
    pins_t                  smp;
    logic [HC_ADDR_W-1:0]   a_prev;
    logic [HC_SETTLE_W-1:0] cnt_q;
    logic [HC_SETTLE_W-1:0] cnt_cur;
    logic                   addr_ok;
    mode_e                  mode;
    logic [7:0]             q;
    logic [7:0]             q_next;

    assign raw = {pins.p15, pins.p14, pins.p13, pins.p3, pins.p2, pins.p1};

    hc_sync #(
        .W         ($bits(pins_t)),
        .RESET_VAL (PIN_RST)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (smp)
    );

    // Count for the address sampled this cycle, so a fresh address is never qualified.
    always_comb begin
        cnt_cur = '0;
        if (smp.a == a_prev)
            cnt_cur = (cnt_q >= SETTLE_MAX) ? SETTLE_MAX : cnt_q + 4'd1;
        addr_ok = (cnt_cur == SETTLE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_prev <= '0;
            cnt_q  <= '0;
        end else begin
            a_prev <= smp.a;
            cnt_q  <= cnt_cur;
        end
    end

    assign mode = mode_e'({smp.le_n, smp.mr_n});

    always_comb begin
        q_next = q;
        case (mode)
            MODE_LATCH: if (addr_ok) q_next[smp.a] = smp.d;
            MODE_DEMUX: begin
                q_next = '0;
                if (addr_ok) q_next[smp.a] = smp.d;
            end
            MODE_CLEAR: q_next = '0;
            default:    q_next = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= q_next;
    end

    assign pins.p4  = q[0];
    assign pins.p5  = q[1];
    assign pins.p6  = q[2];
    assign pins.p7  = q[3];
    assign pins.p9  = q[4];
    assign pins.p10 = q[5];
    assign pins.p11 = q[6];
    assign pins.p12 = q[7];

endmodule
